// File: rtl/calc_op_sequencer.sv
// Multi-cycle add/sub/mul/div controller for the keypad calculator, built on one shared adder.
// Optional macro CALC_SIGNED_SUB_EN: when a - b goes negative, return the wrapped difference instead of an error.
module calc_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  state_t               state, state_next;
  logic [3:0]           op;
  logic [WIDTH-1:0]     a, b;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [CNT_W-1:0]     cnt;
  logic                 last;
  logic [WIDTH:0]       alu_x, alu_y, mul_hi;
  logic                 alu_sub;
  logic [WIDTH+1:0]     alu;
  logic [WIDTH-1:0]     exec_res, iter_res;
  logic                 exec_err, iter_err;
  logic                 long_op;

  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign long_op = (opcode == OP_MUL) || ((opcode == OP_DIV) && (op_b != '0));

  // Shared adder: EXEC does a+b / a-b, mul adds multiplicand to the high half,
  // div trial-subtracts the divisor from the shifted partial remainder.
  always_comb begin
    alu_x   = '0;
    alu_y   = '0;
    alu_sub = 1'b0;
    case (state)
      EXEC: begin
        alu_x   = {1'b0, a};
        alu_y   = {1'b0, b};
        alu_sub = (op == OP_SUB);
      end
      ITER: begin
        if (op == OP_MUL) begin
          alu_x = {1'b0, acc[2*WIDTH-1:WIDTH]};
          alu_y = {1'b0, a};
        end else begin
          alu_x   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
          alu_y   = {1'b0, b};
          alu_sub = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign alu = alu_sub ? ({1'b0, alu_x} - {1'b0, alu_y})
                       : ({1'b0, alu_x} + {1'b0, alu_y});

  // One iteration step; mul shifts right (LSB of multiplier first), div shifts left.
  always_comb begin
    mul_hi   = acc[0] ? alu[WIDTH:0] : {1'b0, acc[2*WIDTH-1:WIDTH]};
    acc_next = acc;
    if (op == OP_MUL) begin
      acc_next = {mul_hi, acc[WIDTH-1:1]};
    end else if (!alu[WIDTH+1]) begin
      acc_next = {alu[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end
    iter_res = acc_next[WIDTH-1:0];
    iter_err = (op == OP_MUL) ? (|acc_next[2*WIDTH-1:WIDTH]) : 1'b0;
  end

  always_comb begin
    exec_res = '0;
    exec_err = 1'b1;
    case (op)
      OP_ADD: begin
        exec_res = alu[WIDTH-1:0];
        exec_err = alu[WIDTH];
      end
      OP_SUB: begin
        if (alu[WIDTH+1]) begin
`ifdef CALC_SIGNED_SUB_EN
          exec_res = alu[WIDTH-1:0];
          exec_err = 1'b0;
`else
          exec_res = '0;
          exec_err = 1'b1;
`endif
        end else begin
          exec_res = alu[WIDTH-1:0];
          exec_err = 1'b0;
        end
      end
      default: begin
        exec_res = '0;
        exec_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = long_op ? ITER : EXEC;
        end
      end
      EXEC: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      ITER: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) begin
      state_next = IDLE;
    end
  end

  // Datapath registers; clear freezes everything so result/err keep their old values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op     <= '0;
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else if (!clear) begin
      case (state)
        IDLE: begin
          if (start) begin
            op  <= opcode;
            a   <= op_a;
            b   <= op_b;
            cnt <= '0;
            acc <= (opcode == OP_MUL) ? {{WIDTH{1'b0}}, op_b} : {{WIDTH{1'b0}}, op_a};
          end
        end
        EXEC: begin
          result <= exec_res;
          err    <= exec_err;
        end
        ITER: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            result <= iter_res;
            err    <= iter_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Randomized self-checking bench for calc_op_sequencer against an arithmetic reference model.
module tb_calc_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] op_a, op_b;
  logic        clear;
  logic        busy, done, err;
  logic [15:0] result;

  int vectors    = 0;
  int miscompares = 0;
  logic [15:0] last_res;
  logic        last_err;

  calc_op_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .clear(clear),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {err, result} straight from the arithmetic rules.
  function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [31:0] p;
    case (op)
      4'hA: begin
        s = {1'b0, a} + {1'b0, b};
        return s;
      end
      4'hB: begin
        if (b > a) begin
`ifdef CALC_SIGNED_SUB_EN
          return {1'b0, 16'(a - b)};
`else
          return {1'b1, 16'h0000};
`endif
        end
        return {1'b0, 16'(a - b)};
      end
      4'hC: begin
        p = 32'(a) * 32'(b);
        return {|p[31:16], p[15:0]};
      end
      4'hD: begin
        if (b == 16'h0) return {1'b1, 16'h0000};
        return {1'b0, 16'(a / b)};
      end
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [15:0] b);
    if (op == 4'hC || (op == 4'hD && b != 16'h0)) return 17;
    return 2;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit spur);
    logic [16:0] exp;
    int lat;
    int k;
    bit seen;
    exp = model(op, a, b);
    lat = latency(op, b);
    @(negedge clk);
    opcode = op; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; opcode = 4'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
    check("busy_t1", 32'(busy), 32'd1);
    check("done_t1", 32'(done), 32'd0);
    seen = 1'b0;
    for (k = 2; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (spur && k == 3) begin
        start = 1'b1; opcode = 4'hA;
      end
    end
    if (!seen) begin
      check("done_seen", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(k), 32'(lat));
      check("busy_at_done", 32'(busy), 32'd0);
      check("result", 32'(result), 32'(exp[15:0]));
      check("err", 32'(err), 32'(exp[16]));
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("result_hold", 32'(result), 32'(exp[15:0]));
      last_res = exp[15:0];
      last_err = exp[16];
    end
    $display("op=%h a=%h b=%h -> result=%h err=%b latency=%0d", op, a, b, result, err, k);
  endtask

  initial begin
    int sel;
    logic [3:0]  r_op;
    logic [15:0] r_a, r_b;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; opcode = 4'h0; op_a = '0; op_b = '0;
    last_res = '0; last_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    run_op(4'hA, 16'h00FF, 16'h0001, 1'b0);
    run_op(4'hA, 16'hFFFF, 16'h0002, 1'b0);
    run_op(4'hC, 16'h0012, 16'h0034, 1'b1);
    run_op(4'hC, 16'h0100, 16'h0100, 1'b0);
    run_op(4'hD, 16'h1234, 16'h0010, 1'b1);
    run_op(4'hD, 16'h1234, 16'h0000, 1'b0);
    run_op(4'hB, 16'h0003, 16'h0005, 1'b0);
    run_op(4'hB, 16'h0005, 16'h0003, 1'b0);
    run_op(4'h7, 16'h1111, 16'h2222, 1'b0);
    run_op(4'hD, 16'hFFFF, 16'h0001, 1'b0);
    run_op(4'hC, 16'hFFFF, 16'hFFFF, 1'b0);

    // clear with a simultaneous start at T+5 of a multiply
    @(negedge clk);
    opcode = 4'hC; op_a = 16'h0123; op_b = 16'h0045; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1; start = 1'b1; opcode = 4'hA;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check("clear_busy", 32'(busy), 32'd0);
    check("clear_done", 32'(done), 32'd0);
    check("clear_result", 32'(result), 32'(last_res));
    check("clear_err", 32'(err), 32'(last_err));
    begin
      int dcount;
      dcount = 0;
      repeat (20) begin
        @(negedge clk);
        if (done) dcount++;
      end
      check("clear_no_done", 32'(dcount), 32'd0);
    end
    $display("clear at T+5 of mul: busy=%b result=%h err=%b", busy, result, err);

    // reset at T+8 of another multiply
    @(negedge clk);
    opcode = 4'hC; op_a = 16'h0077; op_b = 16'h0099; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_result", 32'(result), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    $display("reset at T+8 of mul: busy=%b done=%b result=%h err=%b", busy, done, result, err);

    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      r_a = 16'($urandom);
      r_b = 16'($urandom);
      case (sel)
        0, 1: r_op = 4'hA;
        2, 3: r_op = 4'hB;
        4, 5: begin
          r_op = 4'hC;
          if ($urandom_range(0, 1) == 0) begin
            r_a = {8'h00, r_a[7:0]};
            r_b = {8'h00, r_b[7:0]};
          end
        end
        6, 7: begin
          r_op = 4'hD;
          if ($urandom_range(0, 1) == 0) r_b = {12'h000, r_b[3:0]};
        end
        8: begin
          r_op = 4'($urandom_range(0, 9));
          if ($urandom_range(0, 1) == 0) r_op = 4'hE;
        end
        default: begin
          r_op = 4'hD;
          r_b = 16'h0000;
        end
      endcase
      run_op(r_op, r_a, r_b, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
